// File: rtl/alu_cond_stage.sv
// Condition-evaluation stage behind the ALU: holds NZCV, evaluates the condition code and
// presents a registered write-back beat on a valid/ready handshake.
module alu_cond_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] result_in,
    input  logic [3:0]  aluflags_in,
    input  logic [3:0]  cond,
    input  logic [1:0]  flag_write,
    input  logic        reg_write,
    input  logic [3:0]  rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] wb_data,
    output logic [3:0]  wb_rd,
    output logic        wb_en,
    output logic [3:0]  flags,
    output logic [15:0] fail_count
);

    logic       accept;
    logic       pass;
    logic       n, z, c, v;
    logic [3:0] flags_d;

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    // Condition is judged against the stored flags only; no bypass from the ALU.
    assign {n, z, c, v} = flags;

    always_comb begin
        pass = 1'b1;
        case (cond)
            4'b0000: pass = z;
            4'b0001: pass = ~z;
            4'b0010: pass = c;
            4'b0011: pass = ~c;
            4'b0100: pass = n;
            4'b0101: pass = ~n;
            4'b0110: pass = v;
            4'b0111: pass = ~v;
            4'b1000: pass = c & ~z;
            4'b1001: pass = ~c | z;
            4'b1010: pass = (n == v);
            4'b1011: pass = (n != v);
            4'b1100: pass = ~z & (n == v);
            4'b1101: pass = z | (n != v);
            default: pass = 1'b1;
        endcase
    end

    always_comb begin
        flags_d = flags;
        if (accept && pass) begin
            if (flag_write[1]) flags_d[3:2] = aluflags_in[3:2];
            if (flag_write[0]) flags_d[1:0] = aluflags_in[1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            wb_data    <= 32'h0;
            wb_rd      <= 4'h0;
            wb_en      <= 1'b0;
            flags      <= 4'h0;
            fail_count <= 16'h0;
        end else begin
            flags <= flags_d;
            if (accept) begin
                out_valid <= 1'b1;
                wb_data   <= result_in;
                wb_rd     <= rd;
                wb_en     <= reg_write & pass;
                if (!pass && fail_count != 16'hFFFF) begin
                    fail_count <= fail_count + 16'd1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
